// File: rtl/fetch_buffer_pkg.sv
// fetch_buffer_pkg: shared types and sizing for the fetch buffer.
package fetch_buffer_pkg;
  localparam int FB_N = 3;
  localparam int FETCH_BUF_SZ = 8;
  typedef logic [31:0] data_t;
  typedef logic [31:0] addr_t;
  typedef logic [$clog2(FETCH_BUF_SZ)-1:0] fb_idx_t;
  typedef struct packed {
    data_t instr;
    addr_t pc;
  } fetch_buf_entry_t;
endpackage

// File: rtl/fb_window_check.sv
// fb_window_check: valid mask of the head window, stopping at the first PC break or the occupancy limit.
module fb_window_check
  import fetch_buffer_pkg::*;
#(
  parameter int N = FB_N,
  parameter int DEPTH = FETCH_BUF_SZ
) (
  input  addr_t                      pc [N],
  input  logic [$clog2(DEPTH+1)-1:0] count,
  output logic [N-1:0]               fetch_valid
);
  localparam int CW = $clog2(DEPTH+1);
  logic ok;
  always_comb begin
    fetch_valid = '0;
    ok = 1'b1;
    for (int i = 0; i < N; i++) begin
      ok = ok && (CW'(i) < count) && (pc[i] == pc[0] + 32'(4 * i));
      fetch_valid[i] = ok;
    end
  end
endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer: circular instruction queue presenting a PC-contiguous head window to dispatch.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int N = FB_N,
  parameter int DEPTH = FETCH_BUF_SZ
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [$clog2(N+1)-1:0]     enq_count,
  input  data_t                      enq_instr [N],
  input  addr_t                      enq_pc [N],
  output logic                       enq_accept,
  output logic [$clog2(DEPTH+1)-1:0] free_slots,
  output data_t                      ff_instr [N],
  output addr_t                      ff_pc,
  output logic [N-1:0]               fetch_valid,
  input  logic [$clog2(N+1)-1:0]     dispatch_count
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int NW = $clog2(N+1);
  fetch_buf_entry_t mem [DEPTH];
  logic [IW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [NW-1:0] vcnt, deq;
  addr_t win_pc [N];
  always_comb begin
    for (int i = 0; i < N; i++) begin
      win_pc[i] = mem[head + IW'(i)].pc;
      ff_instr[i] = fetch_valid[i] ? mem[head + IW'(i)].instr : '0;
    end
  end
  fb_window_check #(.N(N), .DEPTH(DEPTH)) u_check (
    .pc(win_pc),
    .count(count),
    .fetch_valid(fetch_valid)
  );
  // The mask is contiguous, so its popcount is the window length.
  always_comb begin
    vcnt = '0;
    for (int i = 0; i < N; i++) vcnt = vcnt + NW'(fetch_valid[i]);
  end
  assign deq = dispatch_count < vcnt ? dispatch_count : vcnt;
  assign ff_pc = count != '0 ? mem[head].pc : '0;
  assign free_slots = CW'(DEPTH) - count;
  assign enq_accept = reset && !flush && enq_count != '0 && CW'(enq_count) <= free_slots;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= head + IW'(deq);
      if (enq_accept) tail <= tail + IW'(enq_count);
      count <= count + (enq_accept ? CW'(enq_count) : CW'(0)) - CW'(deq);
    end
  end
  always_ff @(posedge clock) begin
    for (int i = 0; i < N; i++)
      if (enq_accept && NW'(i) < enq_count) mem[tail + IW'(i)] <= '{instr: enq_instr[i], pc: enq_pc[i]};
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      assert (count <= CW'(DEPTH));
      assert ((fetch_valid & (fetch_valid + N'(1))) == '0);
      assert (!(enq_accept && int'(count) + int'(enq_count) > DEPTH));
    end
  end
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed checks of enqueue, window, dequeue clamp, full, wrap, flush and async reset.
module tb_fetch_buffer;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  enq_count = '0;
  logic [31:0] enq_instr [3];
  logic [31:0] enq_pc [3];
  logic        enq_accept;
  logic [3:0]  free_slots;
  logic [31:0] ff_instr [3];
  logic [31:0] ff_pc;
  logic [2:0]  fetch_valid;
  logic [1:0]  dispatch_count = '0;
  int checks = 0;
  int errors = 0;
  fetch_buffer #(.N(3), .DEPTH(8)) dut (
    .clock(clock),
    .reset(reset),
    .flush(flush),
    .enq_count(enq_count),
    .enq_instr(enq_instr),
    .enq_pc(enq_pc),
    .enq_accept(enq_accept),
    .free_slots(free_slots),
    .ff_instr(ff_instr),
    .ff_pc(ff_pc),
    .fetch_valid(fetch_valid),
    .dispatch_count(dispatch_count)
  );
  always #5 clock = ~clock;
  function automatic logic [31:0] iw(input logic [31:0] pc);
    return pc ^ 32'hdead_0000;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic offer(input int c, input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2);
    enq_count = 2'(c);
    enq_pc[0] = p0;
    enq_pc[1] = p1;
    enq_pc[2] = p2;
    for (int i = 0; i < 3; i++) enq_instr[i] = iw(enq_pc[i]);
    #1;
  endtask
  initial begin
    offer(0, 0, 0, 0);
    repeat (2) tick;
    reset = 1'b1;
    #1;
    chk("rst_free", 32'(free_slots), 8);
    chk("rst_fv", 32'(fetch_valid), 0);
    chk("rst_pc", ff_pc, 0);
    // fill to 5 then reset asynchronously mid-cycle
    offer(3, 32'h0, 32'h4, 32'h8);
    tick;
    offer(2, 32'hc, 32'h10, 32'h0);
    chk("t1_acc", 32'(enq_accept), 1);
    tick;
    offer(0, 0, 0, 0);
    chk("t1_free5", 32'(free_slots), 3);
    chk("t1_fv", 32'(fetch_valid), 3'b111);
    offer(3, 32'h0, 32'h4, 32'h8);
    reset = 1'b0;
    #1;
    chk("t1_async_free", 32'(free_slots), 8);
    chk("t1_async_fv", 32'(fetch_valid), 0);
    chk("t1_async_acc", 32'(enq_accept), 0);
    chk("t1_async_pc", ff_pc, 0);
    tick;
    reset = 1'b1;
    offer(1, 32'h0, 32'h0, 32'h0);
    enq_instr[0] = 32'h55;
    tick;
    offer(0, 0, 0, 0);
    chk("t1_fresh_fv", 32'(fetch_valid), 3'b001);
    chk("t1_fresh_pc", ff_pc, 0);
    chk("t1_fresh_instr", ff_instr[0], 32'h55);
    chk("t1_fresh_free", 32'(free_slots), 7);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    // test 2: contiguous window then partial dispatch
    offer(3, 32'h100, 32'h104, 32'h108);
    chk("t2_acc", 32'(enq_accept), 1);
    chk("t2_no_bypass", 32'(fetch_valid), 0);
    tick;
    offer(0, 0, 0, 0);
    chk("t2_pc", ff_pc, 32'h100);
    chk("t2_fv", 32'(fetch_valid), 3'b111);
    chk("t2_free", 32'(free_slots), 5);
    chk("t2_instr2", ff_instr[2], iw(32'h108));
    dispatch_count = 2;
    tick;
    dispatch_count = 0;
    chk("t2_pc2", ff_pc, 32'h108);
    chk("t2_fv2", 32'(fetch_valid), 3'b001);
    chk("t2_instr_inv", ff_instr[1], 0);
    dispatch_count = 1;
    tick;
    dispatch_count = 0;
    chk("t2_empty_fv", 32'(fetch_valid), 0);
    // test 3: taken branch breaks the window; dispatch clamp
    offer(3, 32'h200, 32'h204, 32'h300);
    tick;
    offer(0, 0, 0, 0);
    chk("t3_fv", 32'(fetch_valid), 3'b011);
    chk("t3_pc", ff_pc, 32'h200);
    dispatch_count = 3;
    tick;
    dispatch_count = 0;
    chk("t3_pc2", ff_pc, 32'h300);
    chk("t3_fv2", 32'(fetch_valid), 3'b001);
    chk("t3_free", 32'(free_slots), 7);
    // test 4: fill to 7, reject 2, dequeue 3, retry accepted, then full
    offer(3, 32'h304, 32'h308, 32'h30c);
    tick;
    offer(3, 32'h310, 32'h314, 32'h318);
    tick;
    offer(2, 32'h31c, 32'h320, 32'h0);
    dispatch_count = 3;
    #1;
    chk("t4_free1", 32'(free_slots), 1);
    chk("t4_fv", 32'(fetch_valid), 3'b111);
    chk("t4_reject", 32'(enq_accept), 0);
    tick;
    dispatch_count = 0;
    #1;
    chk("t4_free4", 32'(free_slots), 4);
    chk("t4_retry_acc", 32'(enq_accept), 1);
    tick;
    offer(2, 32'h324, 32'h328, 32'h0);
    chk("t4_free2", 32'(free_slots), 2);
    chk("t4_pc", ff_pc, 32'h30c);
    tick;
    offer(1, 32'h32c, 32'h0, 32'h0);
    chk("t4_full", 32'(free_slots), 0);
    chk("t4_full_rej", 32'(enq_accept), 0);
    tick;
    offer(0, 0, 0, 0);
    chk("t4_full_hold", 32'(free_slots), 0);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    // test 5: six single rounds move head/tail to 6, then a group wraps 6,7,0
    for (int k = 0; k < 6; k++) begin
      offer(1, 32'h10 + 32'(4 * k), 32'h0, 32'h0);
      tick;
      offer(0, 0, 0, 0);
      dispatch_count = 1;
      chk("t5_round_pc", ff_pc, 32'h10 + 32'(4 * k));
      tick;
      dispatch_count = 0;
    end
    offer(3, 32'h40, 32'h44, 32'h48);
    tick;
    offer(0, 0, 0, 0);
    chk("t5_fv", 32'(fetch_valid), 3'b111);
    chk("t5_pc", ff_pc, 32'h40);
    chk("t5_i0", ff_instr[0], iw(32'h40));
    chk("t5_i1", ff_instr[1], iw(32'h44));
    chk("t5_i2", ff_instr[2], iw(32'h48));
    // test 6: flush overrides same-cycle enqueue and dequeue
    offer(1, 32'h4c, 32'h0, 32'h0);
    tick;
    offer(3, 32'h500, 32'h504, 32'h508);
    flush = 1'b1;
    dispatch_count = 2;
    #1;
    chk("t6_free4", 32'(free_slots), 4);
    chk("t6_acc", 32'(enq_accept), 0);
    chk("t6_pre_pc", ff_pc, 32'h40);
    chk("t6_pre_fv", 32'(fetch_valid), 3'b111);
    tick;
    flush = 1'b0;
    dispatch_count = 0;
    offer(0, 0, 0, 0);
    chk("t6_free", 32'(free_slots), 8);
    chk("t6_fv", 32'(fetch_valid), 0);
    chk("t6_pc", ff_pc, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
